// File: rtl/tcm_banked_ctrl_pkg.sv
// Shared constants for the banked TCM controller: default geometry, supported
// read-latency range and the round-robin pointer encoding.
package tcm_banked_ctrl_pkg;

  localparam int TCM_AW = 14;
  localparam int TCM_DW = 32;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  typedef enum logic {
    RR_D_FIRST = 1'b0,
    RR_I_FIRST = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/tcm_banked_ctrl_tcm_bank.sv
// One TCM bank: synchronous write with per-byte enables, registered read.
// A bank sees at most one access per cycle; the top arbitrates beforehand.
module tcm_bank
  import tcm_banked_ctrl_pkg::*;
#(
  parameter int RW = TCM_AW - 1,
  parameter int DW = TCM_DW,
  parameter int MW = DW / 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [RW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [MW-1:0] wem,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**RW];

  // rdata only moves on a read, so it stays put while the word is in flight.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < MW; b++) begin
          if (wem[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/tcm_banked_ctrl.sv
// Banked TCM serving an instruction-fetch port and a load/store port with
// round-robin conflict arbitration; TCM_PERF_CNT_EN adds a conflict counter.
module tcm_banked_ctrl
  import tcm_banked_ctrl_pkg::*;
#(
  parameter int AW     = TCM_AW,
  parameter int DW     = TCM_DW,
  parameter int BANKS  = 2,
  parameter int RD_LAT = 1,
  parameter int MW     = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_rsp_valid,
  output logic [DW-1:0] i_rsp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  input  logic [MW-1:0] d_req_wem,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data
`ifdef TCM_PERF_CNT_EN
  ,
  output logic [31:0]   perf_conflict_cnt
`endif
);

  localparam int BW  = $clog2(BANKS);
  localparam int BIW = (BW > 0) ? BW : 1;
  localparam int RW  = AW - BW;
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  function automatic logic [BIW-1:0] bank_of(input logic [AW-1:0] a);
    logic [BIW-1:0] b;
    b = a[BIW-1:0];
    return (BANKS == 1) ? '0 : b;
  endfunction

  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> BW;
    return s[RW-1:0];
  endfunction

  logic [BIW-1:0] i_bank, d_bank;
  logic [RW-1:0]  i_row, d_row;
  logic           conflict;
  rr_ptr_e        rr_q;

  assign i_bank = bank_of(i_req_addr);
  assign d_bank = bank_of(d_req_addr);
  assign i_row  = row_of(i_req_addr);
  assign d_row  = row_of(d_req_addr);

  // Handshake: a request transfers on a cycle where valid && ready. Ready is
  // a pure function of both valids, both bank indices and the RR pointer, is
  // never high while its own valid is low, and responses have no backpressure.
  assign conflict    = i_req_valid && d_req_valid && (i_bank == d_bank);
  assign i_req_ready = i_req_valid && (!conflict || rr_q == RR_I_FIRST);
  assign d_req_ready = d_req_valid && (!conflict || rr_q == RR_D_FIRST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q <= RR_D_FIRST;
    end else if (conflict) begin
      rr_q <= (rr_q == RR_D_FIRST) ? RR_I_FIRST : RR_D_FIRST;
    end
  end

`ifdef TCM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
    end else if (conflict && perf_conflict_cnt != '1) begin
      perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

  logic [DW-1:0] bank_rdata [BANKS];

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic sel_i, sel_d;
    assign sel_i = i_req_ready && (i_bank == BIW'(b));
    assign sel_d = d_req_ready && (d_bank == BIW'(b));

    tcm_bank #(.RW(RW), .DW(DW), .MW(MW)) u_bank (
      .clk   (clk),
      .en    (sel_i || sel_d),
      .we    (sel_d && d_req_we),
      .addr  (sel_d ? d_row : i_row),
      .wdata (d_req_wdata),
      .wem   (d_req_wem),
      .rdata (bank_rdata[b])
    );
  end

  // Port 0 is D, port 1 is I.
  logic [1:0]     acc_rd;
  logic [BIW-1:0] acc_bank [2];
  logic [1:0]     rsp_valid;
  logic [DW-1:0]  rsp_data [2];

  assign acc_rd[0]   = d_req_ready && !d_req_we;
  assign acc_rd[1]   = i_req_ready;
  assign acc_bank[0] = d_bank;
  assign acc_bank[1] = i_bank;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [LAT-1:0] vld_q;
    logic [BIW-1:0] sel_q;
    logic [DW-1:0]  s1_data, last_data, hold_q;

    always_comb begin
      s1_data = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (sel_q == BIW'(b)) s1_data = bank_rdata[b];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q  <= '0;
        sel_q  <= '0;
        hold_q <= '0;
      end else begin
        vld_q[0] <= acc_rd[p];
        for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
        if (acc_rd[p]) sel_q <= acc_bank[p];
        if (vld_q[LAT-1]) hold_q <= last_data;
      end
    end

    if (LAT == 1) begin : g_lat1
      assign last_data = s1_data;
    end else begin : g_latn
      // Stage data is captured from the bank before a later read can move it.
      logic [DW-1:0] dat_q [LAT-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < LAT - 1; k++) dat_q[k] <= '0;
        end else begin
          if (vld_q[0]) dat_q[0] <= s1_data;
          for (int k = 1; k < LAT - 1; k++) begin
            if (vld_q[k]) dat_q[k] <= dat_q[k-1];
          end
        end
      end
      assign last_data = dat_q[LAT-2];
    end

    assign rsp_valid[p] = vld_q[LAT-1];
    assign rsp_data[p]  = vld_q[LAT-1] ? last_data : hold_q;
  end

  assign d_rsp_valid = rsp_valid[0];
  assign d_rsp_data  = rsp_data[0];
  assign i_rsp_valid = rsp_valid[1];
  assign i_rsp_data  = rsp_data[1];

endmodule

// File: tb/tb_tcm_banked_ctrl.sv
// Bench for tcm_banked_ctrl: two instances (read latency 1 and 3) share one
// stimulus stream and are checked against a word-array reference model.
module tb_tcm_banked_ctrl;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BANKS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          d_req_valid;
  logic          d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic [3:0]    d_req_wem;

  logic          d1_i_req_ready, d1_i_rsp_valid, d1_d_req_ready, d1_d_rsp_valid;
  logic [DW-1:0] d1_i_rsp_data, d1_d_rsp_data;
  logic          d3_i_req_ready, d3_i_rsp_valid, d3_d_req_ready, d3_d_rsp_valid;
  logic [DW-1:0] d3_i_rsp_data, d3_d_rsp_data;
`ifdef TCM_PERF_CNT_EN
  logic [31:0]   d1_perf, d3_perf;
`endif

  always #5 clk = ~clk;

  tcm_banked_ctrl #(.AW(AW), .DW(DW), .BANKS(BANKS), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(d1_i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(d1_i_rsp_valid), .i_rsp_data(d1_i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d1_d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wem(d_req_wem),
    .d_rsp_valid(d1_d_rsp_valid), .d_rsp_data(d1_d_rsp_data)
`ifdef TCM_PERF_CNT_EN
    , .perf_conflict_cnt(d1_perf)
`endif
  );

  tcm_banked_ctrl #(.AW(AW), .DW(DW), .BANKS(BANKS), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(d3_i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(d3_i_rsp_valid), .i_rsp_data(d3_i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d3_d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wem(d_req_wem),
    .d_rsp_valid(d3_d_rsp_valid), .d_rsp_data(d3_d_rsp_data)
`ifdef TCM_PERF_CNT_EN
    , .perf_conflict_cnt(d3_perf)
`endif
  );

  // Reference model: word array, RR owner bit, expected responses {due, data}.
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            m_conf   = 0;
  bit            m_i_acc, m_d_acc;
  bit            rr_i_first = 1'b0;
  logic [DW-1:0] ref_mem [256];
  logic [63:0]   exp_q [4][$];
  logic [DW-1:0] last_q [4];
  int            lat [4]  = '{1, 1, 3, 3};
  string         tags [4] = '{"d1_i", "d1_d", "d3_i", "d3_d"};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input int k, input logic v, input logic [DW-1:0] d);
    logic [63:0] e;
    if (exp_q[k].size() > 0 && int'(exp_q[k][0][63:32]) == cyc) begin
      e = exp_q[k].pop_front();
      check($sformatf("%s_rsp_valid@%0d", tags[k], cyc), 64'(v), 64'd1);
      check($sformatf("%s_rsp_data@%0d", tags[k], cyc), 64'(d), 64'(e[31:0]));
      last_q[k] = e[31:0];
    end else begin
      check($sformatf("%s_rsp_valid@%0d", tags[k], cyc), 64'(v), 64'd0);
      check($sformatf("%s_rsp_hold@%0d", tags[k], cyc), 64'(d), 64'(last_q[k]));
    end
  endtask

  // One clock: check readies from the model, advance the model at the edge,
  // then check every response output half a cycle later.
  task automatic tick();
    bit            conflict, i_acc, d_acc;
    logic [DW-1:0] w;
    #1;
    conflict = i_req_valid && d_req_valid &&
               ((int'(i_req_addr) % BANKS) == (int'(d_req_addr) % BANKS));
    i_acc = i_req_valid && (!conflict || rr_i_first);
    d_acc = d_req_valid && (!conflict || !rr_i_first);
    check($sformatf("d1_i_ready@%0d", cyc), 64'(d1_i_req_ready), 64'(i_acc));
    check($sformatf("d1_d_ready@%0d", cyc), 64'(d1_d_req_ready), 64'(d_acc));
    check($sformatf("d3_i_ready@%0d", cyc), 64'(d3_i_req_ready), 64'(i_acc));
    check($sformatf("d3_d_ready@%0d", cyc), 64'(d3_d_req_ready), 64'(d_acc));
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        last_q[k] = '0;
      end
      rr_i_first = 1'b0;
      i_acc = 1'b0;
      d_acc = 1'b0;
    end else begin
      if (conflict) begin
        rr_i_first = !rr_i_first;
        m_conf++;
      end
      if (i_acc) begin
        exp_q[0].push_back({32'(cyc + lat[0] - 1), ref_mem[i_req_addr[7:0]]});
        exp_q[2].push_back({32'(cyc + lat[2] - 1), ref_mem[i_req_addr[7:0]]});
      end
      if (d_acc && !d_req_we) begin
        exp_q[1].push_back({32'(cyc + lat[1] - 1), ref_mem[d_req_addr[7:0]]});
        exp_q[3].push_back({32'(cyc + lat[3] - 1), ref_mem[d_req_addr[7:0]]});
      end
      if (d_acc && d_req_we) begin
        w = ref_mem[d_req_addr[7:0]];
        for (int b = 0; b < 4; b++) begin
          if (d_req_wem[b]) w[b*8 +: 8] = d_req_wdata[b*8 +: 8];
        end
        ref_mem[d_req_addr[7:0]] = w;
      end
    end
    m_i_acc = i_acc;
    m_d_acc = d_acc;
    @(negedge clk);
    check_rsp(0, d1_i_rsp_valid, d1_i_rsp_data);
    check_rsp(1, d1_d_rsp_valid, d1_d_rsp_data);
    check_rsp(2, d3_i_rsp_valid, d3_i_rsp_data);
    check_rsp(3, d3_d_rsp_valid, d3_d_rsp_data);
  endtask

  task automatic drv_i(input bit v, input int a);
    i_req_valid = v;
    i_req_addr  = AW'(a);
  endtask

  task automatic drv_d(input bit v, input bit we, input int a,
                       input logic [DW-1:0] wd, input logic [3:0] m);
    d_req_valid = v;
    d_req_we    = we;
    d_req_addr  = AW'(a);
    d_req_wdata = wd;
    d_req_wem   = m;
  endtask

  task automatic idle();
    drv_i(1'b0, 0);
    drv_d(1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) last_q[k] = '0;
    idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Write then fetch the same word on the next cycle.
    drv_d(1'b1, 1'b1, 'h004, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    drv_i(1'b1, 'h004);
    tick();
    idle();
    repeat (3) tick();

    // Preload the model-covered window.
    for (int a = 0; a < 64; a++) begin
      if (a != 'h004) begin
        drv_d(1'b1, 1'b1, a, $urandom, 4'hF);
        tick();
      end
    end
    idle();
    tick();

    // Different banks in the same cycle.
    drv_i(1'b1, 'h010);
    drv_d(1'b1, 1'b0, 'h011, '0, '0);
    tick();
    idle();
    repeat (3) tick();

    // Byte-masked write, mask-zero write, readback on both ports.
    drv_d(1'b1, 1'b1, 'h030, 32'h11223344, 4'hF);
    tick();
    drv_d(1'b1, 1'b1, 'h030, 32'hAABBCCDD, 4'h5);
    tick();
    drv_d(1'b1, 1'b1, 'h031, $urandom, 4'h0);
    tick();
    drv_d(1'b1, 1'b0, 'h031, '0, '0);
    drv_i(1'b1, 'h030);
    tick();
    idle();
    repeat (3) tick();

    // Back-to-back D reads.
    for (int a = 0; a < 4; a++) begin
      drv_d(1'b1, 1'b0, a, '0, '0);
      tick();
    end
    idle();
    repeat (4) tick();

    // Three conflicting cycles on bank 0: D, I, D.
    drv_i(1'b1, 'h020);
    drv_d(1'b1, 1'b0, 'h022, '0, '0);
    repeat (3) tick();
`ifdef TCM_PERF_CNT_EN
    check("d1_perf_after_conflicts", 64'(d1_perf), 64'(m_conf));
    check("d3_perf_after_conflicts", 64'(d3_perf), 64'(m_conf));
`endif
    drv_d(1'b0, 1'b0, 0, '0, '0);
    tick();
    idle();
    repeat (3) tick();

    // Reset with reads in flight, then a conflict that D must win.
    drv_d(1'b1, 1'b0, 'h005, '0, '0);
    tick();
    drv_d(1'b1, 1'b0, 'h006, '0, '0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    drv_i(1'b1, 'h020);
    drv_d(1'b1, 1'b0, 'h022, '0, '0);
    tick();
    drv_d(1'b0, 1'b0, 0, '0, '0);
    tick();
    idle();
    repeat (4) tick();

    // Random traffic; a pending request holds until accepted.
    for (int n = 0; n < 400; n++) begin
      if (!i_req_valid || m_i_acc) begin
        if ($urandom_range(0, 3) != 0) drv_i(1'b1, $urandom_range(0, 63));
        else drv_i(1'b0, 0);
      end
      if (!d_req_valid || m_d_acc) begin
        if ($urandom_range(0, 3) != 0)
          drv_d(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
                4'($urandom_range(0, 15)));
        else drv_d(1'b0, 1'b0, 0, '0, '0);
      end
      tick();
    end
    if (i_req_valid && !m_i_acc) begin
      drv_d(1'b0, 1'b0, 0, '0, '0);
      tick();
    end
    if (d_req_valid && !m_d_acc) begin
      drv_i(1'b0, 0);
      tick();
    end
    idle();
    repeat (5) tick();
`ifdef TCM_PERF_CNT_EN
    check("d1_perf_final", 64'(d1_perf), 64'(m_conf));
    check("d3_perf_final", 64'(d3_perf), 64'(m_conf));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcm_banked_ctrl.md
Name: tcm_banked_ctrl

Overview:
- Parametrised successor to the single-port-per-bus SRAM model behind the CPU top level.
- One shared, word-addressed TCM array, split into BANKS interleaved banks, serves two requestors:
  - I port: instruction fetch, read-only.
  - D port: load/store, read or masked write.
- Uses valid/ready request handshakes, a configurable read-latency pipeline and round-robin arbitration on bank conflicts.
- Sits between the core and the memory array; replaces the fixed-latency, conflict-free SRAM pair.

Parameters:
- AW, 14: word address width per port (array depth = 2**AW words).
- DW, 32: data width in bits; must be a multiple of 8.
- BANKS, 2: bank count, power of 2 in range 1..8. Bank index = addr[log2(BANKS)-1:0].
- RD_LAT, 1: read latency in cycles, range 1..3.
- MW, DW/8: write-mask width. Derived; not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch accepted this cycle
- i_req_addr  in  AW  fetch word address
- i_rsp_valid  out  1  fetch data valid
- i_rsp_data  out  DW  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  AW  data word address
- d_req_wdata  in  DW  write data
- d_req_wem  in  MW  byte write enables
- d_rsp_valid  out  1  read data valid (reads only)
- d_rsp_data  out  DW  read data
- perf_conflict_cnt  out  32  conflict counter (present only with TCM_PERF_CNT_EN)

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous and active-low on rst_n.
- Reset values:
  - i_rsp_valid = 0, d_rsp_valid = 0.
  - Response data registers = 0.
  - Round-robin pointer = D-first.
  - perf_conflict_cnt = 0.
  - Memory contents are not reset.
- Ready generation:
  - Ready is combinational from both valids and bank indices. No valid-to-ready dependency loop toward the requestor.
  - Ready is asserted only when the same port's valid is high; it is 0 when that port is idle.
- Arbitration:
  - Both ports valid, different banks: both accepted in the same cycle.
  - Both ports valid, same bank (conflict): the pointer holder wins and the other ready = 0. The pointer then moves to the loser, so the loser wins the next conflict.
  - The pointer changes only on conflicts.
  - BANKS = 1: every simultaneous request is a conflict.
- Accepted write: applies to the addressed word at the clock edge, masked per byte by d_req_wem. No response is generated.
- Write with wem = 0: accepted; no change to the array.
- Read-after-write: a D write accepted in cycle N is visible to any read accepted in cycle N+1 or later, on either port.
- Accepted read: rsp_valid pulses exactly RD_LAT cycles after acceptance, with the data sampled at the accept edge. There is one pipeline valid bit per stage per port.
- Response path:
  - No response backpressure; requestors must sink responses.
  - Responses return in request order; back-to-back reads give back-to-back responses.
  - Between responses, rsp_data holds its last value.
- Unaccepted requests: not queued. The requestor keeps valid and address stable until ready.
- Reset mid-operation: all in-flight pipeline valid bits are cleared and no response is emitted for them. The pointer returns to D-first.
- Address wrap: none; addresses are taken modulo 2**AW.

Optional Feature:
- Macro: TCM_PERF_CNT_EN.
- Defined:
  - perf_conflict_cnt port exists.
  - The counter increments by 1 each cycle in which a bank conflict stalls one port.
  - It saturates at 0xFFFFFFFF.
- Undefined: the port and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines package holds:
  - default TCM AW/DW constants;
  - the RD_LAT range limits;
  - the round-robin pointer encoding (RR_D_FIRST = 0, RR_I_FIRST = 1).
- One natural sub-module, tcm_bank:
  - a single bank: synchronous-write, synchronous-read memory with byte mask;
  - instantiated BANKS times in a generate loop.
- Arbitration, muxing and the latency pipeline stay in the top module.

Test Plan:
- Reset, then D write addr 0x004 data 0xDEADBEEF wem 0xF; I read 0x004 next cycle (RD_LAT = 1) -> i_rsp_valid exactly one cycle later with 0xDEADBEEF.
- BANKS = 2: I read 0x010 and D read 0x011 in the same cycle -> both ready = 1; both responses valid in the same cycle, with data in order.
- Conflict with BANKS = 2: I and D both hit bank 0 (0x020 / 0x022) for 3 consecutive cycles -> accept order D, I, D; perf_conflict_cnt = 3 when the macro is defined.
- Byte mask: preload 0x11223344; D write 0xAABBCCDD with wem 0x5 -> readback 0x11BB33DD.
- RD_LAT = 3: reads to 0x000..0x003 issued back-to-back on D -> d_rsp_valid high for cycles 3..6 after the first accept, with data in order.
- Reset asserted with two reads in flight -> no rsp_valid pulse after reset; the next conflict is won by D.
